spi_frame_echo: RTL and testbench
=================================

# spi_frame_echo

Parametrised serial frame transceiver for the SPI slave path. It receives start/stop-framed words on `mosi` and buffers them in a small FIFO. It retransmits each buffered word, framed the same way, on `miso`. It replaces the fixed 8-bit, single-buffer receive/transmit pair with configurable word width, buffer depth and bit order, plus abort, overflow and framing-error handling.

## Interface
- `WIDTH`, 8, data bits per frame (2..32)
- `DEPTH`, 4, FIFO entries (power of two, 2..16)
- `MSB_FIRST`, 1, 1 = MSB first on both lines, 0 = LSB first
- `spi_clk`  in  1  clock; all logic on posedge
- `rst_n`  in  1  reset rst_n, synchronous, active-low; clock spi_clk
- `cs_n`  in  1  chip select, active low; high aborts both FSMs
- `mosi`  in  1  serial input, idle high
- `miso`  out  1  serial output, registered, idle high
- `fifo_level`  out  $clog2(DEPTH)+1  words currently buffered
- `overflow`  out  1  sticky: a valid frame was dropped because the FIFO was full
- `frame_err`  out  1  sticky: bad stop bit (or bad parity, see Configuration)
- `tx_busy`  out  1  high while the TX FSM is not in T_IDLE

## Operation
- Reset values: `miso`=1, `fifo_level`=0, `overflow`=0, `frame_err`=0, `tx_busy`=0. Both FSMs go to idle; FIFO pointers are cleared.
- Frame format: start bit 0, then WIDTH data bits, then [parity bit], then stop bit 1. Each bit occupies one `spi_clk` cycle.
- RX FSM states: R_IDLE, R_DATA, R_PAR, R_STOP.
  - R_IDLE: `cs_n`=0 and `mosi`=0 (start bit) moves to R_DATA. The bit counter loads WIDTH-1.
  - R_DATA: shifts `mosi` into the shift register in MSB_FIRST order. The FSM leaves after WIDTH bits.
  - R_STOP with `mosi`=1: push if the FIFO is not full. If it is full, drop the word and set `overflow`.
  - R_STOP with `mosi`=0: drop the word and set `frame_err`. The FSM returns to R_IDLE either way.
- TX FSM states: T_IDLE, T_START, T_DATA, T_PAR, T_STOP.
  - T_IDLE: `cs_n`=0 and FIFO non-empty moves to T_START. The FSM latches the FIFO head without popping it.
  - T_START drives 0. T_DATA drives WIDTH bits. T_STOP drives 1.
  - The FIFO pops on T_STOP exit only. The FSM then returns to T_IDLE, so there is at least one idle-high cycle between frames.
- `cs_n`=1 in any state forces both FSMs to idle at the next edge and drives `miso`=1.
  - An RX word in progress is discarded and no flag is set.
  - An aborted TX word stays at the FIFO head and is resent in full later.
- Push and pop in the same cycle: both happen and `fifo_level` is unchanged. This also applies when the FIFO is full, so no overflow is flagged.
- FIFO pointers wrap modulo DEPTH. `fifo_level` saturates at DEPTH by construction.
- Sticky flags clear only on reset.

## Timing
- `miso` is a register: a state entered at edge N drives its bit from edge N onward.
- RX latency: stop bit sampled at edge S; `fifo_level` increments at S.
- Loopback latency with TX idle: T_IDLE sees non-empty at edge S+1; the start bit appears on `miso` after S+1; the first data bit appears after S+2.
- Back-to-back RX frames are allowed: a start bit may be sampled in the cycle immediately after the stop bit.
- A full TX frame takes WIDTH+2 cycles (+1 with parity). There is 1 idle cycle before the next frame.

## Configuration
- `SPI_FRAME_PARITY_EN` defined:
  - R_PAR and T_PAR are present, and frames carry an even-parity bit after the data.
  - An RX parity mismatch drops the word and sets `frame_err`; this check is evaluated at R_STOP.
  - TX inserts the computed parity bit.
- Not defined: R_PAR and T_PAR are not present, and no parity logic is generated.

## Structure
- Package `spi_frame_pkg` holds:
  - the RX and TX state typedefs (R_IDLE..R_STOP, T_IDLE..T_STOP);
  - the idle-level constant (1) and the start-bit constant (0);
  - a `parity` function.
- Sub-module `spi_frame_fifo`: synchronous FIFO (WIDTH, DEPTH) with push/pop, a head output, full/empty, and a level output.
- The top level contains the two FSMs, the shift registers, the bit counters and the flags.

## Test plan
- Reset, then one frame 0xA9 on `mosi` (WIDTH=8, MSB first) -> `fifo_level`=1 at the stop edge, then `miso` sends 0, 1,0,1,0,1,0,0,1, then 1. `fifo_level` returns to 0.
- 5 back-to-back frames 0x01..0x05 with DEPTH=4 and TX held off by toggling `cs_n` only between frames -> `overflow`=1 and the 5th word is dropped. `miso` later returns 0x01..0x04 in order.
- Frame 0x3C with stop bit 0 -> `frame_err`=1, `fifo_level` stays 0, and `miso` stays high.
- `cs_n` raised during TX bit 3 of 0x55 -> `miso`=1 at the next edge and `fifo_level` stays 1. After `cs_n`=0 again, the full 0x55 frame is resent.
- `rst_n`=0 mid-RX and mid-TX -> all outputs return to their reset values at the next edge, and no partial word is pushed.
- With `SPI_FRAME_PARITY_EN`: 0x07 sent with parity 0 (wrong) -> `frame_err`=1 and the word is dropped. 0x07 sent with parity 1 -> accepted and echoed with parity 1.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame echo path.
// Optional even-parity framing is enabled with SPI_FRAME_PARITY_EN.
package spi_frame_pkg;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
`ifdef SPI_FRAME_PARITY_EN
    R_PAR,
`endif
    R_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
`ifdef SPI_FRAME_PARITY_EN
    T_PAR,
`endif
    T_STOP
  } tx_state_e;

  // Even-parity bit: makes the total count of ones (data + parity) even.
  function automatic logic parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/spi_frame_fifo.sv
// Synchronous word FIFO; push while full is accepted only together with a pop.
module spi_frame_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     spi_clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  always_ff @(posedge spi_clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; only pointer-qualified entries are ever read.
  always_ff @(posedge spi_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head_c  = mem[rd_ptr];
  assign full_c  = (count == CNTW'(DEPTH));
  assign empty_c = (count == '0);
  assign level   = count;

endmodule

// File: rtl/spi_frame_echo.sv
// Receives framed words on mosi, buffers them, and echoes them framed on miso.
// Define SPI_FRAME_PARITY_EN to add an even-parity bit to both directions.
module spi_frame_echo
  import spi_frame_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                   spi_clk,
  input  logic                   rst_n,
  input  logic                   cs_n,
  input  logic                   mosi,
  output logic                   miso,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   frame_err,
  output logic                   tx_busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  rx_state_e        rx_state, rx_next;
  logic [CW-1:0]    rx_cnt, rx_cnt_next;
  logic [WIDTH-1:0] rx_sh, rx_sh_next;
  tx_state_e        tx_state, tx_next;
  logic [CW-1:0]    tx_cnt, tx_cnt_next;
  logic [WIDTH-1:0] tx_sh, tx_sh_next;
  logic             push, pop, ovf_set, ferr_set, miso_next, par_ok;
  logic [WIDTH-1:0] head_c;
  logic             full_c, empty_c;
`ifdef SPI_FRAME_PARITY_EN
  logic             rx_par, rx_par_next, tx_par, tx_par_next;
  assign par_ok = (parity(32'(rx_sh)) == rx_par);
`else
  assign par_ok = 1'b1;
`endif

  spi_frame_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .spi_clk (spi_clk),
    .rst_n   (rst_n),
    .push    (push),
    .wdata   (rx_sh),
    .pop     (pop),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level   (fifo_level)
  );

  // RX: deserialise one frame and push it on a good stop bit.
  always_comb begin
    rx_next     = rx_state;
    rx_cnt_next = rx_cnt;
    rx_sh_next  = rx_sh;
    push        = 1'b0;
    ovf_set     = 1'b0;
    ferr_set    = 1'b0;
`ifdef SPI_FRAME_PARITY_EN
    rx_par_next = rx_par;
`endif
    if (cs_n) begin
      rx_next = R_IDLE;
    end else begin
      unique case (rx_state)
        R_IDLE: begin
          if (mosi == START_BIT) begin
            rx_next     = R_DATA;
            rx_cnt_next = CW'(WIDTH - 1);
          end
        end
        R_DATA: begin
          if (MSB_FIRST) rx_sh_next = {rx_sh[WIDTH-2:0], mosi};
          else           rx_sh_next = {mosi, rx_sh[WIDTH-1:1]};
          if (rx_cnt == '0) begin
`ifdef SPI_FRAME_PARITY_EN
            rx_next = R_PAR;
`else
            rx_next = R_STOP;
`endif
          end else begin
            rx_cnt_next = rx_cnt - CW'(1);
          end
        end
`ifdef SPI_FRAME_PARITY_EN
        R_PAR: begin
          rx_par_next = mosi;
          rx_next     = R_STOP;
        end
`endif
        R_STOP: begin
          rx_next = R_IDLE;
          if (mosi == IDLE_LVL && par_ok) begin
            if (!full_c || pop) push    = 1'b1;
            else                ovf_set = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end
        default: rx_next = R_IDLE;
      endcase
    end
  end

  // TX: serialise the FIFO head; pop only once the stop bit has completed.
  always_comb begin
    tx_next     = tx_state;
    tx_cnt_next = tx_cnt;
    tx_sh_next  = tx_sh;
    pop         = 1'b0;
    miso_next   = IDLE_LVL;
`ifdef SPI_FRAME_PARITY_EN
    tx_par_next = tx_par;
`endif
    if (cs_n) begin
      tx_next = T_IDLE;
    end else begin
      unique case (tx_state)
        T_IDLE: begin
          if (!empty_c) begin
            tx_next    = T_START;
            tx_sh_next = head_c;
`ifdef SPI_FRAME_PARITY_EN
            tx_par_next = parity(32'(head_c));
`endif
          end
        end
        T_START: begin
          tx_next     = T_DATA;
          tx_cnt_next = CW'(WIDTH - 1);
        end
        T_DATA: begin
          if (tx_cnt == '0) begin
`ifdef SPI_FRAME_PARITY_EN
            tx_next = T_PAR;
`else
            tx_next = T_STOP;
`endif
          end else begin
            tx_cnt_next = tx_cnt - CW'(1);
          end
        end
`ifdef SPI_FRAME_PARITY_EN
        T_PAR: tx_next = T_STOP;
`endif
        T_STOP: begin
          tx_next = T_IDLE;
          pop     = 1'b1;
        end
        default: tx_next = T_IDLE;
      endcase
    end
    // miso is registered from the state being entered
    unique case (tx_next)
      T_START: miso_next = START_BIT;
      T_DATA: begin
        miso_next = MSB_FIRST ? tx_sh[WIDTH-1] : tx_sh[0];
        if (MSB_FIRST) tx_sh_next = {tx_sh[WIDTH-2:0], 1'b0};
        else           tx_sh_next = {1'b0, tx_sh[WIDTH-1:1]};
      end
`ifdef SPI_FRAME_PARITY_EN
      T_PAR:   miso_next = tx_par;
`endif
      default: miso_next = IDLE_LVL;
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (!rst_n) begin
      rx_state  <= R_IDLE;
      rx_cnt    <= '0;
      rx_sh     <= '0;
      tx_state  <= T_IDLE;
      tx_cnt    <= '0;
      tx_sh     <= '0;
      miso      <= IDLE_LVL;
      tx_busy   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_FRAME_PARITY_EN
      rx_par    <= 1'b0;
      tx_par    <= 1'b0;
`endif
    end else begin
      rx_state  <= rx_next;
      rx_cnt    <= rx_cnt_next;
      rx_sh     <= rx_sh_next;
      tx_state  <= tx_next;
      tx_cnt    <= tx_cnt_next;
      tx_sh     <= tx_sh_next;
      miso      <= miso_next;
      tx_busy   <= (tx_next != T_IDLE);
      overflow  <= overflow | ovf_set;
      frame_err <= frame_err | ferr_set;
`ifdef SPI_FRAME_PARITY_EN
      rx_par    <= rx_par_next;
      tx_par    <= tx_par_next;
`endif
    end
  end

endmodule

// File: tb/tb_spi_frame_echo.sv
// Directed bench for spi_frame_echo (WIDTH=8, DEPTH=4, MSB first).
// Parity cases are included when SPI_FRAME_PARITY_EN is defined.
module tb_spi_frame_echo;

  logic       spi_clk;
  logic       rst_n;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       frame_err;
  logic       tx_busy;

  int n_tests;
  int n_fail;

  spi_frame_echo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .spi_clk    (spi_clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .tx_busy    (tx_busy)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge spi_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    tick();
  endtask

  // Start bit, 8 data bits MSB first, optional parity, stop; line idles high after.
  task automatic rx_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
`ifdef SPI_FRAME_PARITY_EN
    send_bit((^d) ^ bad_par);
`endif
    send_bit(stop);
    mosi = 1'b1;
  endtask

  task automatic get_frame(output logic [7:0] d, output logic p, output logic stop);
    bit found;
    found = 1'b0;
    d = '0;
    p = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (miso == 1'b0) found = 1'b1;
    end
    check("tx_start_seen", 32'(found), 1);
    if (!found) return;
    for (int i = 0; i < 8; i++) begin
      tick();
      d = {d[6:0], miso};
    end
`ifdef SPI_FRAME_PARITY_EN
    tick();
    p = miso;
`endif
    tick();
    stop = miso;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  d;
    logic        p;
    logic        s;
`ifdef SPI_FRAME_PARITY_EN
    logic [10:0] seq_a9;
    seq_a9 = 11'b0_1010_1001_0_1;
`else
    logic [9:0]  seq_a9;
    seq_a9 = 10'b0_1010_1001_1;
`endif
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_miso",      32'(miso), 1);
    check("rst_level",     32'(fifo_level), 0);
    check("rst_overflow",  32'(overflow), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_tx_busy",   32'(tx_busy), 0);

    // Single frame loopback with exact latency.
    cs_n = 1'b0;
    rx_frame(8'hA9, 1'b1, 1'b0);
    check("a9_level_at_stop", 32'(fifo_level), 1);
    for (int k = $bits(seq_a9) - 1; k >= 0; k--) begin
      tick();
      check("a9_miso_bit", 32'(miso), 32'(seq_a9[k]));
      if (k == $bits(seq_a9) - 1) check("a9_tx_busy", 32'(tx_busy), 1);
    end
    tick();
    check("a9_level_after_pop", 32'(fifo_level), 0);
    check("a9_tx_idle",         32'(tx_busy), 0);

    // Five frames while TX is repeatedly aborted before its pop.
    for (int k = 1; k <= 5; k++) begin
      cs_n = 1'b0;
      rx_frame(8'(k), 1'b1, 1'b0);
      cs_n = 1'b1;
      tick();
    end
    check("ovf_flag",     32'(overflow), 1);
    check("ovf_level",    32'(fifo_level), 4);
    check("ovf_no_ferr",  32'(frame_err), 0);
    cs_n = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      get_frame(d, p, s);
      check("ovf_echo_data", 32'(d), 32'(k));
      check("ovf_echo_stop", 32'(s), 1);
    end
    tick();
    check("ovf_drained", 32'(fifo_level), 0);

    // Bad stop bit.
    rx_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_flag",  32'(frame_err), 1);
    check("ferr_level", 32'(fifo_level), 0);
    repeat (3) tick();
    check("ferr_miso_idle", 32'(miso), 1);
    check("ferr_tx_idle",   32'(tx_busy), 0);

    // Abort during TX data bit 3, then full resend.
    rx_frame(8'h55, 1'b1, 1'b0);
    check("abort_level_pre", 32'(fifo_level), 1);
    repeat (5) tick();
    cs_n = 1'b1;
    tick();
    check("abort_miso",  32'(miso), 1);
    check("abort_level", 32'(fifo_level), 1);
    check("abort_busy",  32'(tx_busy), 0);
    cs_n = 1'b0;
    get_frame(d, p, s);
    check("resend_data", 32'(d), 32'h55);
    check("resend_stop", 32'(s), 1);
`ifdef SPI_FRAME_PARITY_EN
    check("resend_par",  32'(p), 0);
`endif
    tick();
    check("resend_level", 32'(fifo_level), 0);

    // Reset with RX and TX both mid-frame.
    rx_frame(8'h12, 1'b1, 1'b0);
    tick();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    mosi  = 1'b1;
    rst_n = 1'b0;
    tick();
    check("mid_rst_miso",      32'(miso), 1);
    check("mid_rst_level",     32'(fifo_level), 0);
    check("mid_rst_overflow",  32'(overflow), 0);
    check("mid_rst_frame_err", 32'(frame_err), 0);
    check("mid_rst_tx_busy",   32'(tx_busy), 0);
    rst_n = 1'b1;
    repeat (12) tick();
    check("post_rst_level", 32'(fifo_level), 0);
    check("post_rst_miso",  32'(miso), 1);

`ifdef SPI_FRAME_PARITY_EN
    // 0x07 has three ones, so the correct even-parity bit is 1.
    rx_frame(8'h07, 1'b1, 1'b1);
    check("par_bad_ferr",  32'(frame_err), 1);
    check("par_bad_level", 32'(fifo_level), 0);
    rx_frame(8'h07, 1'b1, 1'b0);
    check("par_ok_level", 32'(fifo_level), 1);
    get_frame(d, p, s);
    check("par_echo_data", 32'(d), 32'h07);
    check("par_echo_par",  32'(p), 1);
    check("par_echo_stop", 32'(s), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
